wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: load results win, ex results queue in a 2-entry in-order FIFO; optional WB_ARBITER_BYPASS_EN.
// Latency: 1 cycle from selection to wen/rd/dataD (ex via FIFO 2+ cycles, 1 with bypass into an empty FIFO).
// Backpressure: ex_ready drops when the FIFO holds 2 entries or during reset; the load path never stalls.
module wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_valid,
    input  logic [ADDR_WIDTH-1:0] ld_rd,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [ADDR_WIDTH-1:0] ex_rd,
    input  logic [DATA_WIDTH-1:0] ex_data,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0] dataD,
    output logic [1:0]            fifo_count
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_ent_t;

    wb_ent_t               mem_q [2];
    logic [1:0]            count_q, count_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] data_q;

    logic    push, enq, pop, sel_vld;
    wb_ent_t sel;

    // Full FIFO refuses ex even if a pop happens this cycle (no push-through).
    assign ex_ready = !rst && (count_q != 2'd2);
    assign push     = ex_valid && ex_ready;

    always_comb begin
        sel_vld = 1'b0;
        sel     = mem_q[rd_ptr_q];
        pop     = 1'b0;
        enq     = push;
        if (ld_valid) begin
            sel_vld = 1'b1;
            sel     = '{rd: ld_rd, data: ld_data};
        end else if (count_q != 2'd0) begin
            sel_vld = 1'b1;
            pop     = 1'b1;
        end
`ifdef WB_ARBITER_BYPASS_EN
        else if (push) begin
            sel_vld = 1'b1;
            sel     = '{rd: ex_rd, data: ex_data};
            enq     = 1'b0;
        end
`endif
        count_d  = count_q + {1'b0, enq} - {1'b0, pop};
        wr_ptr_d = wr_ptr_q ^ enq;
        rd_ptr_d = rd_ptr_q ^ pop;
        // Writes to index 0 are dropped; the entry is still consumed.
        wen_d    = sel_vld && (sel.rd != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            wen_q    <= 1'b0;
            rd_q     <= '0;
            data_q   <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wen_q    <= wen_d;
            if (wen_d) begin
                rd_q   <= sel.rd;
                data_q <= sel.data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= '{rd: ex_rd, data: ex_data};
        end
    end

    assign wen        = wen_q;
    assign rd         = rd_q;
    assign dataD      = data_q;
    assign fifo_count = count_q;

endmodule
